// File: rtl/dp_ram_port_arbiter.sv
// Round-robin arbiter that lets two OBI-style requesters share port B of the testbench RAM.
// Grants are issued in the same cycle as the request, and the response comes back one cycle later.
module dp_ram_port_arbiter #(
    parameter int ADDR_WIDTH = 22,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,

    input  logic                  m0_req_i,
    output logic                  m0_gnt_o,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic                  m0_we_i,
    input  logic [3:0]            m0_be_i,
    input  logic [31:0]           m0_wdata_i,
    output logic                  m0_rvalid_o,
    output logic [31:0]           m0_rdata_o,

    input  logic                  m1_req_i,
    output logic                  m1_gnt_o,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic                  m1_we_i,
    input  logic [3:0]            m1_be_i,
    input  logic [31:0]           m1_wdata_i,
    output logic                  m1_rvalid_o,
    output logic [31:0]           m1_rdata_o,

    output logic                  ram_en_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic                  ram_we_o,
    output logic [3:0]            ram_be_o,
    output logic [31:0]           ram_wdata_o,
    input  logic [31:0]           ram_rdata_i,

    output logic [CNT_WIDTH-1:0]  m0_gnt_cnt_o,
    output logic [CNT_WIDTH-1:0]  m1_gnt_cnt_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic                 last_q;
    logic                 rsp_vld_q;
    logic                 rsp_owner_q;
    logic                 rsp_read_q;
    logic [CNT_WIDTH-1:0] m0_cnt_q;
    logic [CNT_WIDTH-1:0] m1_cnt_q;

    logic can_grant;
    logic gnt0;
    logic gnt1;
    logic any_gnt;
    logic win_we;

    // When both requesters ask, the one that was not served last wins.
    always_comb begin
        can_grant = ~stall_i & ~rst_i;
        gnt0      = can_grant & m0_req_i & (~m1_req_i | last_q);
        gnt1      = can_grant & m1_req_i & (~m0_req_i | ~last_q);
        any_gnt   = gnt0 | gnt1;
        win_we    = gnt1 ? m1_we_i : m0_we_i;
    end

    always_comb begin
        m0_gnt_o    = gnt0;
        m1_gnt_o    = gnt1;
        ram_en_o    = any_gnt;
        ram_addr_o  = m0_addr_i;
        ram_wdata_o = m0_wdata_i;
        ram_we_o    = 1'b0;
        ram_be_o    = 4'b0000;
        if (gnt1) begin
            ram_addr_o  = m1_addr_i;
            ram_wdata_o = m1_wdata_i;
            ram_we_o    = m1_we_i;
            ram_be_o    = m1_be_i;
        end else if (gnt0) begin
            ram_we_o = m0_we_i;
            ram_be_o = m0_be_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q      <= 1'b1;
            rsp_vld_q   <= 1'b0;
            rsp_owner_q <= 1'b0;
            rsp_read_q  <= 1'b0;
            m0_cnt_q    <= '0;
            m1_cnt_q    <= '0;
        end else begin
            rsp_vld_q <= any_gnt;
            if (any_gnt) begin
                last_q      <= gnt1;
                rsp_owner_q <= gnt1;
                rsp_read_q  <= ~win_we;
            end
            if (gnt0 && m0_cnt_q != CNT_MAX) begin
                m0_cnt_q <= m0_cnt_q + CNT_WIDTH'(1);
            end
            if (gnt1 && m1_cnt_q != CNT_MAX) begin
                m1_cnt_q <= m1_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // Gating with rst_i drops any response that was in flight and clears the counters right away.
    always_comb begin
        m0_rvalid_o  = ~rst_i & rsp_vld_q & ~rsp_owner_q;
        m1_rvalid_o  = ~rst_i & rsp_vld_q & rsp_owner_q;
        m0_rdata_o   = (m0_rvalid_o & rsp_read_q) ? ram_rdata_i : 32'h0;
        m1_rdata_o   = (m1_rvalid_o & rsp_read_q) ? ram_rdata_i : 32'h0;
        m0_gnt_cnt_o = rst_i ? '0 : m0_cnt_q;
        m1_gnt_cnt_o = rst_i ? '0 : m1_cnt_q;
    end

endmodule

// File: tb/tb_dp_ram_port_arbiter.sv
// Self-checking bench for dp_ram_port_arbiter.
// It contains a behavioural RAM and a transaction-level reference model.
module tb_dp_ram_port_arbiter;

    localparam int AW = 22;
    localparam int CW = 16;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          stall_i = 1'b0;
    logic          m0_req_i = 1'b0, m1_req_i = 1'b0;
    logic          m0_gnt_o, m1_gnt_o;
    logic [AW-1:0] m0_addr_i = '0, m1_addr_i = '0;
    logic          m0_we_i = 1'b0, m1_we_i = 1'b0;
    logic [3:0]    m0_be_i = '0, m1_be_i = '0;
    logic [31:0]   m0_wdata_i = '0, m1_wdata_i = '0;
    logic          m0_rvalid_o, m1_rvalid_o;
    logic [31:0]   m0_rdata_o, m1_rdata_o;
    logic          ram_en_o, ram_we_o;
    logic [AW-1:0] ram_addr_o;
    logic [3:0]    ram_be_o;
    logic [31:0]   ram_wdata_o;
    logic [31:0]   ram_rdata_i = '0;
    logic [CW-1:0] m0_gnt_cnt_o, m1_gnt_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] init_mem  [256];
    logic [31:0] ram_mem   [256];
    logic [31:0] model_mem [256];
    logic        ram_loaded = 1'b0;

    // Reference model state
    int          mdl_last = 1;
    int          mdl_cnt [2] = '{0, 0};
    bit          mdl_pend = 1'b0;
    int          mdl_owner = 0;
    bit          mdl_read = 1'b0;
    logic [31:0] mdl_data = '0;

    dp_ram_port_arbiter #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i),
        .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i),
        .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i),
        .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .ram_en_o(ram_en_o), .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
        .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i),
        .m0_gnt_cnt_o(m0_gnt_cnt_o), .m1_gnt_cnt_o(m1_gnt_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // The RAM writes on the enable edge and registers read data. When it is not reading, it drives junk on rdata.
    always @(posedge clk_i) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= init_mem[i];
            ram_loaded <= 1'b1;
        end else if (ram_en_o && ram_we_o) begin
            for (int b = 0; b < 4; b++)
                if (ram_be_o[b]) ram_mem[ram_addr_o[9:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
        end
        if (ram_loaded && ram_en_o && !ram_we_o) ram_rdata_i <= ram_mem[ram_addr_o[9:2]];
        else                                     ram_rdata_i <= $urandom;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic nextCycle;
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input int who, input bit req, input logic [AW-1:0] addr,
                                 input bit we, input logic [3:0] be, input logic [31:0] wdata);
        if (who == 0) begin
            m0_req_i = req; m0_addr_i = addr; m0_we_i = we; m0_be_i = be; m0_wdata_i = wdata;
        end else begin
            m1_req_i = req; m1_addr_i = addr; m1_we_i = we; m1_be_i = be; m1_wdata_i = wdata;
        end
    endtask

    // Every cycle, the model is compared against the DUT and then advanced by one clock.
    always @(negedge clk_i) begin : compare
        int          w;
        logic [AW-1:0] a;
        bit          we;
        logic [3:0]  be;
        logic [31:0] wd;
        bit          rv0, rv1;
        w = -1;
        if (!rst_i && !stall_i) begin
            if (m0_req_i && m1_req_i) w = 1 - mdl_last;
            else if (m0_req_i)        w = 0;
            else if (m1_req_i)        w = 1;
        end
        a  = (w == 1) ? m1_addr_i  : m0_addr_i;
        we = (w == 1) ? m1_we_i    : m0_we_i;
        be = (w == 1) ? m1_be_i    : m0_be_i;
        wd = (w == 1) ? m1_wdata_i : m0_wdata_i;
        checkOutput("m0_gnt", 64'(m0_gnt_o), 64'(w == 0));
        checkOutput("m1_gnt", 64'(m1_gnt_o), 64'(w == 1));
        checkOutput("ram_en", 64'(ram_en_o), 64'(w >= 0));
        if (w >= 0) begin
            checkOutput("ram_addr", 64'(ram_addr_o), 64'(a));
            checkOutput("ram_we", 64'(ram_we_o), 64'(we));
            checkOutput("ram_be", 64'(ram_be_o), 64'(be));
            if (we) checkOutput("ram_wdata", 64'(ram_wdata_o), 64'(wd));
        end else begin
            checkOutput("ram_we_idle", 64'(ram_we_o), 64'(0));
            checkOutput("ram_be_idle", 64'(ram_be_o), 64'(0));
        end
        rv0 = !rst_i && mdl_pend && mdl_owner == 0;
        rv1 = !rst_i && mdl_pend && mdl_owner == 1;
        checkOutput("m0_rvalid", 64'(m0_rvalid_o), 64'(rv0));
        checkOutput("m1_rvalid", 64'(m1_rvalid_o), 64'(rv1));
        checkOutput("m0_rdata", 64'(m0_rdata_o), (rv0 && mdl_read) ? 64'(mdl_data) : 64'(0));
        checkOutput("m1_rdata", 64'(m1_rdata_o), (rv1 && mdl_read) ? 64'(mdl_data) : 64'(0));
        checkOutput("m0_cnt", 64'(m0_gnt_cnt_o), rst_i ? 64'(0) : 64'(mdl_cnt[0]));
        checkOutput("m1_cnt", 64'(m1_gnt_cnt_o), rst_i ? 64'(0) : 64'(mdl_cnt[1]));
        if (rst_i) begin
            mdl_last = 1; mdl_cnt[0] = 0; mdl_cnt[1] = 0; mdl_pend = 1'b0;
        end else begin
            mdl_pend = (w >= 0);
            if (w >= 0) begin
                mdl_last  = w;
                mdl_owner = w;
                if (mdl_cnt[w] < (1 << CW) - 1) mdl_cnt[w] = mdl_cnt[w] + 1;
                mdl_read = !we;
                if (!we) mdl_data = model_mem[a[9:2]];
                else
                    for (int b = 0; b < 4; b++)
                        if (be[b]) model_mem[a[9:2]][8*b +: 8] = wd[8*b +: 8];
            end
        end
    end

    initial begin
        bit g0, g1;
        for (int i = 0; i < 256; i++) begin
            init_mem[i]  = $urandom;
            model_mem[i] = init_mem[i];
        end
        init_mem[64]  = 32'h12345678;
        model_mem[64] = 32'h12345678;

        // Reset, followed by a single m0 read of 0x100
        nextCycle; nextCycle;
        @(negedge clk_i);
        checkOutput("rst_gnt", 64'({m0_gnt_o, m1_gnt_o, ram_en_o}), 64'(0));
        checkOutput("rst_rvalid", 64'({m0_rvalid_o, m1_rvalid_o}), 64'(0));
        checkOutput("rst_cnt", 64'({m0_gnt_cnt_o, m1_gnt_cnt_o}), 64'(0));
        nextCycle;
        rst_i = 1'b0;
        applyStimulus(0, 1, 22'h100, 0, 4'hF, 32'h0);
        @(negedge clk_i);
        checkOutput("t1_gnt0", 64'(m0_gnt_o), 64'(1));
        checkOutput("t1_en", 64'(ram_en_o), 64'(1));
        checkOutput("t1_addr", 64'(ram_addr_o), 64'h100);
        nextCycle;
        applyStimulus(0, 0, 22'h0, 0, 4'h0, 32'h0);
        @(negedge clk_i);
        checkOutput("t1_rvalid0", 64'(m0_rvalid_o), 64'(1));
        checkOutput("t1_rdata0", 64'(m0_rdata_o), 64'h12345678);
        checkOutput("t1_rvalid1", 64'(m1_rvalid_o), 64'(0));

        // Write from m0, immediately followed by a read from m1 of the same word
        nextCycle;
        applyStimulus(0, 1, 22'h100, 1, 4'hF, 32'hDEADBEEF);
        @(negedge clk_i);
        checkOutput("t2_gnt0", 64'(m0_gnt_o), 64'(1));
        nextCycle;
        applyStimulus(0, 0, 22'h0, 0, 4'h0, 32'h0);
        applyStimulus(1, 1, 22'h100, 0, 4'hF, 32'h0);
        @(negedge clk_i);
        checkOutput("t2_rvalid0", 64'(m0_rvalid_o), 64'(1));
        checkOutput("t2_rdata0", 64'(m0_rdata_o), 64'(0));
        checkOutput("t2_gnt1", 64'(m1_gnt_o), 64'(1));
        nextCycle;
        applyStimulus(1, 0, 22'h0, 0, 4'h0, 32'h0);
        @(negedge clk_i);
        checkOutput("t2_rvalid1", 64'(m1_rvalid_o), 64'(1));
        checkOutput("t2_rdata1", 64'(m1_rdata_o), 64'hDEADBEEF);

        // Both requesters held high for 6 cycles should alternate grants
        nextCycle; rst_i = 1'b1;
        nextCycle; rst_i = 1'b0;
        applyStimulus(0, 1, 22'h10, 0, 4'hF, 32'h0);
        applyStimulus(1, 1, 22'h20, 0, 4'hF, 32'h0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_i);
            checkOutput("t3_gnt0", 64'(m0_gnt_o), 64'(k % 2 == 0));
            checkOutput("t3_gnt1", 64'(m1_gnt_o), 64'(k % 2 == 1));
            if (k > 0) checkOutput("t3_rvalid0", 64'(m0_rvalid_o), 64'((k - 1) % 2 == 0));
            nextCycle;
        end
        applyStimulus(0, 0, 22'h0, 0, 4'h0, 32'h0);
        applyStimulus(1, 0, 22'h0, 0, 4'h0, 32'h0);
        @(negedge clk_i);
        checkOutput("t3_rvalid1", 64'(m1_rvalid_o), 64'(1));
        checkOutput("t3_cnt0", 64'(m0_gnt_cnt_o), 64'(3));
        checkOutput("t3_cnt1", 64'(m1_gnt_cnt_o), 64'(3));

        // Stalled cycles issue no grant and leave the priority untouched
        nextCycle; rst_i = 1'b1;
        nextCycle; rst_i = 1'b0;
        applyStimulus(0, 1, 22'h30, 0, 4'hF, 32'h0);
        applyStimulus(1, 1, 22'h34, 0, 4'hF, 32'h0);
        stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            checkOutput("t4_stall_gnt", 64'({m0_gnt_o, m1_gnt_o}), 64'(0));
            checkOutput("t4_stall_en", 64'(ram_en_o), 64'(0));
            nextCycle;
        end
        stall_i = 1'b0;
        @(negedge clk_i);
        checkOutput("t4_gnt0", 64'(m0_gnt_o), 64'(1));
        nextCycle;
        @(negedge clk_i);
        checkOutput("t4_gnt1", 64'(m1_gnt_o), 64'(1));
        nextCycle;
        applyStimulus(0, 0, 22'h0, 0, 4'h0, 32'h0);
        applyStimulus(1, 0, 22'h0, 0, 4'h0, 32'h0);

        // Reset that lands right behind an m1 read must drop its response
        nextCycle;
        applyStimulus(1, 1, 22'h40, 0, 4'hF, 32'h0);
        @(negedge clk_i);
        checkOutput("t5_gnt1", 64'(m1_gnt_o), 64'(1));
        nextCycle;
        applyStimulus(1, 0, 22'h0, 0, 4'h0, 32'h0);
        rst_i = 1'b1;
        @(negedge clk_i);
        checkOutput("t5_rvalid1_rst", 64'(m1_rvalid_o), 64'(0));
        checkOutput("t5_cnt1_rst", 64'(m1_gnt_cnt_o), 64'(0));
        nextCycle;
        rst_i = 1'b0;
        applyStimulus(0, 1, 22'h44, 0, 4'hF, 32'h0);
        applyStimulus(1, 1, 22'h48, 0, 4'hF, 32'h0);
        @(negedge clk_i);
        checkOutput("t5_rvalid1_after", 64'(m1_rvalid_o), 64'(0));
        checkOutput("t5_gnt0_after", 64'(m0_gnt_o), 64'(1));
        checkOutput("t5_cnt1_after", 64'(m1_gnt_cnt_o), 64'(0));
        nextCycle;
        applyStimulus(0, 0, 22'h0, 0, 4'h0, 32'h0);
        applyStimulus(1, 0, 22'h0, 0, 4'h0, 32'h0);

        // Randomized traffic: each requester holds its request until it is granted
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_i);
            g0 = m0_gnt_o;
            g1 = m1_gnt_o;
            nextCycle;
            if (m0_req_i && g0) m0_req_i = 1'b0;
            if (m1_req_i && g1) m1_req_i = 1'b0;
            if (!m0_req_i && ($urandom % 3 != 0))
                applyStimulus(0, 1, {12'h0, 8'($urandom), 2'b00}, 1'($urandom), 4'($urandom), $urandom);
            if (!m1_req_i && ($urandom % 3 != 0))
                applyStimulus(1, 1, {12'h0, 8'($urandom), 2'b00}, 1'($urandom), 4'($urandom), $urandom);
            stall_i = ($urandom % 5 == 0);
            rst_i   = ($urandom % 97 == 0);
        end
        stall_i = 1'b0;
        applyStimulus(0, 0, 22'h0, 0, 4'h0, 32'h0);
        applyStimulus(1, 0, 22'h0, 0, 4'h0, 32'h0);

        // Saturation: 65537 m0 grants
        rst_i = 1'b1;
        nextCycle;
        rst_i = 1'b0;
        applyStimulus(0, 1, 22'h0, 0, 4'hF, 32'h0);
        repeat (65537) nextCycle;
        applyStimulus(0, 0, 22'h0, 0, 4'h0, 32'h0);
        @(negedge clk_i);
        checkOutput("t6_cnt0_sat", 64'(m0_gnt_cnt_o), 64'hFFFF);
        checkOutput("t6_cnt1", 64'(m1_gnt_cnt_o), 64'(0));

        nextCycle;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dp_ram_port_arbiter.md
Name: dp_ram_port_arbiter

Overview:
- Shares the single data port (port B) of the testbench dual-port RAM between two OBI-style requesters: m0 (core data interface) and m1 (testbench loader/debug agent).
- Round-robin arbitration with same-cycle grant, response routing that tracks the RAM's 1-cycle read latency, and TB-controlled grant stalling.
- Saturating per-requester grant counters for coverage.
- Sits between the requesters and the RAM port B pins; instruction port A is untouched.

Parameters:
- ADDR_WIDTH, 22, byte-address width forwarded unchanged to the RAM (the RAM does the word shift).
- CNT_WIDTH, 16, width of each saturating grant counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- stall_i  in  1  when 1, no grant is issued this cycle
- m0_req_i  in  1  request
- m0_gnt_o  out  1  grant, combinational
- m0_addr_i  in  ADDR_WIDTH  byte address
- m0_we_i  in  1  write enable
- m0_be_i  in  4  byte enables
- m0_wdata_i  in  32  write data
- m0_rvalid_o  out  1  response valid
- m0_rdata_o  out  32  read data
- m1_*  (same set as m0_*)  second requester
- ram_en_o  out  1  RAM port enable
- ram_addr_o  out  ADDR_WIDTH  RAM address
- ram_we_o  out  1  RAM write enable
- ram_be_o  out  4  RAM byte enables
- ram_wdata_o  out  32  RAM write data
- ram_rdata_i  in  32  RAM read data, valid 1 cycle after enable
- m0_gnt_cnt_o  out  CNT_WIDTH  m0 grants since reset, saturating
- m1_gnt_cnt_o  out  CNT_WIDTH  m1 grants since reset, saturating

Behaviour:
- State:
  - last_q: last-granted requester.
  - rsp_vld_q, rsp_owner_q, rsp_read_q: one response slot.
  - two grant counters.
- Reset (rst_i=1 at a clock edge):
  - last_q=1, so m0 has priority first.
  - rsp_vld_q=0, counters=0.
  - All outputs 0 in the cycle after reset, while rst_i is held, and until the next grant.
  - An in-flight response is dropped: no rvalid is issued for it.
- Grant (combinational in the same cycle as the request):
  - No grants if stall_i=1 or rst_i=1.
  - Otherwise, with exactly one req high, that requester is granted.
  - With both high, the requester != last_q is granted.
  - At most one gnt is high per cycle.
- On grant:
  - ram_en_o=1 and ram_addr/we/be/wdata are muxed from the winner in the same cycle.
  - Otherwise ram_en_o=0, ram_we_o=0, ram_be_o=0.
  - ram_addr_o/ram_wdata_o are then don't-care; drive m0's values.
  - At the clock edge: last_q<=winner, rsp_vld_q<=1, rsp_owner_q<=winner, rsp_read_q<=~we.
  - Without a grant: rsp_vld_q<=0 and last_q holds.
- Response, exactly 1 cycle after the grant, for both reads and writes:
  - mX_rvalid_o = rsp_vld_q && rsp_owner_q==X.
  - mX_rdata_o = ram_rdata_i when that rvalid is high and rsp_read_q=1; else 0.
  - The non-owner sees rvalid=0 and rdata=0.
- Pipelining:
  - Back-to-back grants every cycle are allowed; one new response slot per cycle, no bubbles.
  - No response backpressure; requesters must accept rvalid.
- Request stability:
  - A requester holds req and its attributes until gnt.
  - Attributes may change in the grant cycle only after the edge.
  - The arbiter does not check this.
- Fairness:
  - Under continuous dual request with stall_i=0, grants strictly alternate.
  - A stalled cycle does not change last_q.
- Counters:
  - Increment by 1 on each grant to the corresponding requester.
  - Saturate at 2^CNT_WIDTH-1; no wrap.
- Read-after-write, same word, grants in consecutive cycles:
  - The read returns the new data, because the RAM write completes at the write's grant edge.
- Same-cycle simultaneous writes are impossible because only one grant is issued per cycle.

Test Plan:
- Reset, then m0 read of 0x100 (RAM word holds 0x12345678) -> m0_gnt_o=1 in the same cycle, ram_en_o=1, ram_addr_o=0x100; next cycle m0_rvalid_o=1, m0_rdata_o=0x12345678, m1_rvalid_o=0.
- m0 write 0xDEADBEEF be=4'b1111 to 0x100 in cycle N, then m1 read 0x100 in N+1 -> m0_rvalid_o at N+1 with rdata 0; m1_rvalid_o at N+2 with rdata 0xDEADBEEF.
- Both req held high for 6 cycles from reset -> grant order m0,m1,m0,m1,m0,m1; gnt_cnt 3/3; one rvalid per cycle with correct owner.
- Both req high, stall_i=1 for 3 cycles, then 0 -> no gnt and ram_en_o=0 during the stall; first grant goes to m0; last_q is unchanged by the stall.
- m1 read granted in cycle N, rst_i=1 in cycle N+1 -> m1_rvalid_o=0 in N+1 and N+2; counters read 0; the next grant after reset goes to m0.
- Force m0 for 65537 single grants (CNT_WIDTH=16) -> m0_gnt_cnt_o saturates at 0xFFFF and stays there; m1_gnt_cnt_o=0.
